// File: rtl/mips_cache_pkg.sv
// Shared types and defaults for the MIPS cache bus arbiter.
//   owner_t               : bus owner encoding, also used as the arbiter FSM state
//   STARVE_LIMIT_DEFAULT  : read grants tolerated while the write buffer waits
//   is_read()             : true for the two read owners
package mips_cache_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2,
        WB    = 2'd3
    } owner_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    function automatic logic is_read(owner_t o);
        return (o == INSTR) || (o == DATA);
    endfunction

endpackage

// File: rtl/mips_cache_arb_pick.sv
// Combinational priority / round-robin decision for the cache bus arbiter.
// Ports:
//   instr_req, data_req   : pending read requests
//   wb_req, wb_hazard     : write buffer non-empty / data read hits a buffered entry
//   starved               : the write buffer has waited through the read-grant limit
//   last_read_data        : 1 when the most recent read grant went to the data side
//   pick                  : owner to grant next (NONE when nobody is asking)
module mips_cache_arb_pick
    import mips_cache_pkg::*;
(
    input  logic       instr_req,
    input  logic       data_req,
    input  logic       wb_req,
    input  logic       wb_hazard,
    input  logic       starved,
    input  logic       last_read_data,
    output logic [1:0] pick
);

    always_comb begin
        pick = NONE;
        // A hazard must drain the buffer first, otherwise the read returns stale data.
        if (wb_req && (wb_hazard || starved)) begin
            pick = WB;
        end else if (instr_req && data_req) begin
            pick = last_read_data ? INSTR : DATA;
        end else if (instr_req) begin
            pick = INSTR;
        end else if (data_req) begin
            pick = DATA;
        end else if (wb_req) begin
            pick = WB;
        end
    end

endmodule

// File: rtl/mips_cache_bus_arbiter.sv
// Arbitrates the instruction fetch, data fetch and write buffer onto one
// Avalon master port. One transfer at a time, one IDLE cycle between transfers.
// Ports:
//   clk, rst (async, active-low)
//   instr_req/instr_addr/instr_done     : instruction read side
//   data_req/data_addr/data_done        : data read side
//   wb_req/wb_addr/wb_writedata/wb_byteenable/wb_hazard/wb_done : write buffer head
//   mem_address/mem_read/mem_write/mem_writedata/mem_byteenable/waitrequest : Avalon master
//   owner, busy                         : current bus owner status
//
// state   | meaning
// NONE    | idle, arbitrating this cycle
// INSTR   | instruction read on the bus
// DATA    | data read on the bus
// WB      | write-buffer head entry being written
module mips_cache_bus_arbiter
    import mips_cache_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_done,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    output logic        data_done,
    input  logic        wb_req,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_writedata,
    input  logic [3:0]  wb_byteenable,
    input  logic        wb_hazard,
    output logic        wb_done,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        waitrequest,
    output logic [1:0]  owner,
    output logic        busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    owner_t           state_q;
    owner_t           state_d;
    owner_t           pick;
    logic [1:0]       pick_raw;
    logic [CNT_W-1:0] starve_cnt;
    logic             last_read_data;
    logic             granting;

    mips_cache_arb_pick u_pick (
        .instr_req      (instr_req),
        .data_req       (data_req),
        .wb_req         (wb_req),
        .wb_hazard      (wb_hazard),
        .starved        (starve_cnt == STARVE_MAX),
        .last_read_data (last_read_data),
        .pick           (pick_raw)
    );

    assign pick     = owner_t'(pick_raw);
    assign granting = (state_q == NONE) && (pick != NONE);
    assign owner    = state_q;
    assign busy     = (state_q != NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done is combinational so the requester sees completion in the same
    // cycle the slave drops waitrequest.
    always_comb begin
        state_d    = state_q;
        instr_done = 1'b0;
        data_done  = 1'b0;
        wb_done    = 1'b0;
        case (state_q)
            NONE:  state_d = pick;
            INSTR: if (!waitrequest) begin instr_done = 1'b1; state_d = NONE; end
            DATA:  if (!waitrequest) begin data_done  = 1'b1; state_d = NONE; end
            WB:    if (!waitrequest) begin wb_done    = 1'b1; state_d = NONE; end
            default: state_d = NONE;
        endcase
    end

    // Address/data are captured on the grant edge only, so requester
    // inputs may change freely while the transfer is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= 32'h0;
            mem_writedata  <= 32'h0;
            mem_byteenable <= 4'b1111;
        end else if (state_q == NONE) begin
            case (pick)
                INSTR: begin
                    mem_read       <= 1'b1;
                    mem_address    <= instr_addr;
                    mem_byteenable <= 4'b1111;
                end
                DATA: begin
                    mem_read       <= 1'b1;
                    mem_address    <= data_addr;
                    mem_byteenable <= 4'b1111;
                end
                WB: begin
                    mem_write      <= 1'b1;
                    mem_address    <= wb_addr;
                    mem_writedata  <= wb_writedata;
                    mem_byteenable <= wb_byteenable;
                end
                default: ;
            endcase
        end else if (!waitrequest) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt     <= '0;
            last_read_data <= 1'b1;
        end else begin
            if (!wb_req) begin
                starve_cnt <= '0;
            end else if (granting && pick == WB) begin
                starve_cnt <= '0;
            end else if (granting && is_read(pick) && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (granting && is_read(pick)) begin
                last_read_data <= (pick == DATA);
            end
        end
    end

endmodule
